idli_sqi_ctrl: RTL and testbench
================================

// Module: idli_sqi_ctrl
// PURPOSE
//  Parametrised quad-SPI (SQI) memory controller driving SQI_NUM memories in lockstep; generalises lo/hi nibble split.
//  Memory n stores nibble n of every word; one full word moves per clock.
//  Sits between fetch/LSU request logic and the SQI pins; issues READ/WRITE bursts with CS/turnaround sequencing.
// PARAMETERS
//  SQI_NUM       2   number of attached memories; data word width = 4*SQI_NUM
//  ADDR_W        16  address width in bits, multiple of 4; sent as ADDR_W/4 nibbles (A)
//  LEN_W         4   burst length field width; burst = i_req_len+1 words (1..2^LEN_W)
//  DUMMY_CYCLES  2   turnaround cycles between address and read data (D), >=1
// PORTS
//  i_sqi_clk     in   1            clock; also SCK seen by the memories
//  i_sqi_rst_n   in   1            asynchronous active-low reset
//  i_req_vld     in   1            request valid
//  o_req_rdy     out  1            controller idle, request accepted on vld&rdy
//  i_req_wr      in   1            1=write burst, 0=read burst
//  i_req_addr    in   ADDR_W       start address, identical on all memories
//  i_req_len     in   LEN_W        burst length minus one
//  o_wr_rdy      out  1            write word accepted this cycle
//  i_wr_data     in   4*SQI_NUM    write word; nibble n -> memory n
//  o_rd_vld      out  1            read word valid (single-cycle pulse, no backpressure)
//  o_rd_data     out  4*SQI_NUM    read word; nibble n <- memory n
//  o_sqi_cs_n    out  1            shared chip select, active low
//  o_sqi_sio     out  4*SQI_NUM    SIO output nibbles, registered
//  o_sqi_sio_oe  out  SQI_NUM      SIO output enable per memory
//  i_sqi_sio     in   4*SQI_NUM    SIO input nibbles
// BEHAVIOUR
//  Reset (async, any state): state IDLE; o_sqi_cs_n=1; o_sqi_sio_oe=0; o_sqi_sio=0; o_rd_vld=0; o_rd_data=0; o_wr_rdy=0; o_req_rdy=1 after release.
//  Reset mid-burst aborts the burst; no further rd_vld/wr_rdy; the memory sees CS rise.
//  o_req_rdy = (state==IDLE). Request fields captured on vld&rdy in cycle T; inputs ignored until back in IDLE.
//  FSM: IDLE -> CMD(2) -> ADDR(A) -> [read: DUMMY(D)] -> DATA(len+1) -> DESEL(1) -> IDLE.
//  CMD: cs_n=0, oe=all, command byte high nibble then low, identical on every memory; READ=8'h03, WRITE=8'h02.
//  ADDR: address MSB nibble first, oe=all.
//  DUMMY: oe=0, cs_n=0, sio output don't-care.
//  DATA read: oe=0; i_sqi_sio sampled at each rising edge ending a DATA cycle; o_rd_data/o_rd_vld registered one cycle later.
//  Read timing: first o_rd_vld at T+4+A+D; exactly len+1 pulses on consecutive cycles; last pulse falls in DESEL.
//  DATA write: oe=all; o_wr_rdy is combinational, high in the cycle before each data cycle (last ADDR cycle, then every DATA cycle except the last).
//  Write timing: exactly len+1 wr_rdy cycles; the word present on an o_wr_rdy cycle drives o_sqi_sio the next cycle.
//  i_wr_data must be valid whenever o_wr_rdy=1; no stall path.
//  DESEL: cs_n=1, oe=0 for one cycle (min CS-high time); o_req_rdy=0 here; earliest next accept is the cycle after.
//  Counters: one shared down-counter sized max(2,A,D,2^LEN_W); reloaded on each state entry; transition when it reaches 0.
//  len=2^LEN_W-1 gives 2^LEN_W words, no overflow. Address wrap inside the memory is not tracked.
//  o_wr_rdy=0 and o_rd_vld=0 outside the windows above.
// CONFIGURATION
//  IDLI_SQI_CTRL_ABORT_EN defined: adds input i_abort (1 bit).
//    i_abort=1 in CMD/ADDR/DUMMY/DATA -> next state DESEL.
//    rd_vld for a word already sampled still emits the following cycle; no further rd_vld/wr_rdy.
//    i_abort is ignored in IDLE and DESEL.
//  Macro undefined: port absent; every accepted burst runs to completion.
// TESTING
//  Reset release -> cs_n=1, oe=0, req_rdy=1, rd_vld=0, wr_rdy=0.
//  Read addr=16'h1234 len=0 at T, mems return 4'hA(m0)/4'h5(m1) -> sio out 0,3,1,2,3,4; rd_vld at T+10 with data 8'h5A.
//  Write addr=16'h00F0 len=3, words 8'h11,22,33,44 -> wr_rdy T+6..T+9; sio 0,2,0,0,F,0 then 11,22,33,44; cs_n rises T+11.
//  Back-to-back: second req_vld held high -> accepted cycle after DESEL; cs_n high exactly 1 cycle between bursts.
//  len=15 read -> exactly 16 consecutive rd_vld pulses, then IDLE.
//  Reset asserted in DATA mid-write -> cs_n=1, oe=0 asynchronously; no further wr_rdy.
//  ABORT_EN: i_abort in ADDR -> DESEL next cycle, zero rd_vld.

Source files
------------

// File: rtl/idli_sqi_ctrl.sv
// idli_sqi_ctrl: quad-SPI (SQI) controller driving SQI_NUM memories in lockstep.
// Memory n holds nibble n of every word, so one full word moves per clock.
// Sequence per burst: CMD(2) -> ADDR(A) -> [read: DUMMY(D)] -> DATA(len+1) -> DESEL(1).
// Optional feature: define IDLI_SQI_CTRL_ABORT_EN to add i_abort, which cuts a
// burst short by jumping straight to DESEL.
module idli_sqi_ctrl #(
    parameter int SQI_NUM      = 2,
    parameter int ADDR_W       = 16,
    parameter int LEN_W        = 4,
    parameter int DUMMY_CYCLES = 2
) (
    input  logic                   i_sqi_clk,
    input  logic                   i_sqi_rst_n,
    input  logic                   i_req_vld,
    output logic                   o_req_rdy,
    input  logic                   i_req_wr,
    input  logic [ADDR_W-1:0]      i_req_addr,
    input  logic [LEN_W-1:0]       i_req_len,
    output logic                   o_wr_rdy,
    input  logic [4*SQI_NUM-1:0]   i_wr_data,
    output logic                   o_rd_vld,
    output logic [4*SQI_NUM-1:0]   o_rd_data,
    output logic                   o_sqi_cs_n,
    output logic [4*SQI_NUM-1:0]   o_sqi_sio,
    output logic [SQI_NUM-1:0]     o_sqi_sio_oe,
`ifdef IDLI_SQI_CTRL_ABORT_EN
    input  logic                   i_abort,
`endif
    input  logic [4*SQI_NUM-1:0]   i_sqi_sio
);

    localparam int A        = ADDR_W / 4;
    localparam int D        = DUMMY_CYCLES;
    localparam int N_WORDS  = 1 << LEN_W;
    localparam int M1       = (A > 2) ? A : 2;
    localparam int M2       = (M1 > D) ? M1 : D;
    localparam int CNT_MAX  = (M2 > N_WORDS) ? M2 : N_WORDS;
    localparam int CW       = $clog2(CNT_MAX);

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CMD   = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_DUMMY = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_DESEL = 3'd5;

    logic [2:0]            state, state_nx;
    logic [CW-1:0]         cnt, cnt_nx;
    logic                  wr_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [LEN_W-1:0]      len_q;
    logic                  abort;
    logic                  busy;
    logic                  wr_cur;
    logic [7:0]            cmd;
    logic [3:0]            nib;
    logic                  cs_n_nx;
    logic [SQI_NUM-1:0]    oe_nx;
    logic [4*SQI_NUM-1:0]  sio_nx;

`ifdef IDLI_SQI_CTRL_ABORT_EN
    assign abort = i_abort;
`else
    assign abort = 1'b0;
`endif

    assign o_req_rdy = (state == S_IDLE);
    assign busy      = (state == S_CMD) || (state == S_ADDR) ||
                       (state == S_DUMMY) || (state == S_DATA);

    // Write words are requested one cycle ahead of the DATA cycle that drives them.
    assign o_wr_rdy = wr_q && !abort &&
                      (((state == S_ADDR) && (cnt == '0)) ||
                       ((state == S_DATA) && (cnt != '0)));

    // Next state and shared down-counter; counter is reloaded on every state entry.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt - CW'(1);
        case (state)
            S_IDLE: begin
                cnt_nx = '0;
                if (i_req_vld) begin
                    state_nx = S_CMD;
                    cnt_nx   = CW'(1);
                end
            end
            S_CMD: if (cnt == '0) begin
                state_nx = S_ADDR;
                cnt_nx   = CW'(A - 1);
            end
            S_ADDR: if (cnt == '0) begin
                if (wr_q) begin
                    state_nx = S_DATA;
                    cnt_nx   = CW'(len_q);
                end else begin
                    state_nx = S_DUMMY;
                    cnt_nx   = CW'(D - 1);
                end
            end
            S_DUMMY: if (cnt == '0) begin
                state_nx = S_DATA;
                cnt_nx   = CW'(len_q);
            end
            S_DATA: if (cnt == '0) begin
                state_nx = S_DESEL;
                cnt_nx   = '0;
            end
            S_DESEL: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
        if (abort && busy) begin
            state_nx = S_DESEL;
            cnt_nx   = '0;
        end
    end

    // The request is only captured in the accept cycle, so CMD entry reads the port directly.
    assign wr_cur = (state == S_IDLE) ? i_req_wr : wr_q;
    assign cmd    = wr_cur ? CMD_WRITE : CMD_READ;

    // Address nibble for the upcoming ADDR cycle; counter value equals nibble index (MSB first).
    always_comb begin
        nib = '0;
        for (int i = 0; i < A; i++) begin
            if (cnt_nx == CW'(i)) nib = addr_q[4*i +: 4];
        end
    end

    // Pin values for the next cycle, derived from the next state so the pins are registered.
    always_comb begin
        cs_n_nx = 1'b1;
        oe_nx   = '0;
        sio_nx  = '0;
        case (state_nx)
            S_CMD: begin
                cs_n_nx = 1'b0;
                oe_nx   = '1;
                sio_nx  = (cnt_nx != '0) ? {SQI_NUM{cmd[7:4]}} : {SQI_NUM{cmd[3:0]}};
            end
            S_ADDR: begin
                cs_n_nx = 1'b0;
                oe_nx   = '1;
                sio_nx  = {SQI_NUM{nib}};
            end
            S_DUMMY: cs_n_nx = 1'b0;
            S_DATA: begin
                cs_n_nx = 1'b0;
                if (wr_q) begin
                    oe_nx  = '1;
                    sio_nx = i_wr_data;
                end
            end
            default: ;
        endcase
    end

    // State, counter and captured request fields.
    always_ff @(posedge i_sqi_clk or negedge i_sqi_rst_n) begin
        if (!i_sqi_rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            wr_q   <= 1'b0;
            addr_q <= '0;
            len_q  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if ((state == S_IDLE) && i_req_vld) begin
                wr_q   <= i_req_wr;
                addr_q <= i_req_addr;
                len_q  <= i_req_len;
            end
        end
    end

    // Registered SQI pins; reset deselects the memories immediately.
    always_ff @(posedge i_sqi_clk or negedge i_sqi_rst_n) begin
        if (!i_sqi_rst_n) begin
            o_sqi_cs_n   <= 1'b1;
            o_sqi_sio_oe <= '0;
            o_sqi_sio    <= '0;
        end else begin
            o_sqi_cs_n   <= cs_n_nx;
            o_sqi_sio_oe <= oe_nx;
            o_sqi_sio    <= sio_nx;
        end
    end

    // Read capture: the word present during a read DATA cycle is presented one cycle later.
    always_ff @(posedge i_sqi_clk or negedge i_sqi_rst_n) begin
        if (!i_sqi_rst_n) begin
            o_rd_vld  <= 1'b0;
            o_rd_data <= '0;
        end else begin
            o_rd_vld <= (state == S_DATA) && !wr_q;
            if ((state == S_DATA) && !wr_q) o_rd_data <= i_sqi_sio;
        end
    end

endmodule

// File: tb/tb_idli_sqi_ctrl.sv
// Bench for idli_sqi_ctrl: table of bursts with cycle-accurate pin expectations,
// read/write data tracked through scoreboard queues, plus hand sequences for
// back-to-back, mid-burst reset and (when enabled) abort.
module tb_idli_sqi_ctrl;
    localparam int SN = 2;
    localparam int AW = 16;
    localparam int LW = 4;
    localparam int DC = 2;
    localparam int A  = AW / 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            req_vld = 1'b0;
    logic            req_rdy;
    logic            req_wr = 1'b0;
    logic [AW-1:0]   req_addr = '0;
    logic [LW-1:0]   req_len = '0;
    logic            wr_rdy;
    logic [4*SN-1:0] wr_data = '0;
    logic            rd_vld;
    logic [4*SN-1:0] rd_data;
    logic            cs_n;
    logic [4*SN-1:0] sio;
    logic [SN-1:0]   sio_oe;
    logic [4*SN-1:0] sio_in = '0;
    logic            abort = 1'b0;

    int errs = 0;
    int checks = 0;

    logic [7:0] rdq[$];
    logic [7:0] wq[$];

    idli_sqi_ctrl #(.SQI_NUM(SN), .ADDR_W(AW), .LEN_W(LW), .DUMMY_CYCLES(DC)) dut (
        .i_sqi_clk    (clk),
        .i_sqi_rst_n  (rst_n),
        .i_req_vld    (req_vld),
        .o_req_rdy    (req_rdy),
        .i_req_wr     (req_wr),
        .i_req_addr   (req_addr),
        .i_req_len    (req_len),
        .o_wr_rdy     (wr_rdy),
        .i_wr_data    (wr_data),
        .o_rd_vld     (rd_vld),
        .o_rd_data    (rd_data),
        .o_sqi_cs_n   (cs_n),
        .o_sqi_sio    (sio),
        .o_sqi_sio_oe (sio_oe),
`ifdef IDLI_SQI_CTRL_ABORT_EN
        .i_abort      (abort),
`endif
        .i_sqi_sio    (sio_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [3:0]  len;
        logic [7:0]  seed;
        int          exp_desel;  // cycle offset from accept at which cs_n returns high
        bit          b2b;        // hold the next request valid during DESEL
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] word(input logic [7:0] seed, input int k);
        return seed + 8'(k * 17);
    endfunction

    // Runs one burst starting on the next cycle; ends at the negedge of the DESEL cycle.
    task automatic do_burst(input vec_t v);
        int ds, de;
        logic [7:0] cmd, w;
        logic [3:0] n;
        ds  = v.wr ? 3 + A : 3 + A + DC;
        de  = ds + int'(v.len);
        cmd = v.wr ? 8'h02 : 8'h03;
        @(negedge clk);
        req_vld = 1'b1; req_wr = v.wr; req_addr = v.addr; req_len = v.len;
        chk("req_rdy_accept", req_rdy, 1);
        chk("cs_n_accept", cs_n, 1);
        for (int c = 1; c <= v.exp_desel; c++) begin
            @(negedge clk);
            if (c == 1) req_vld = 1'b0;
            chk("req_rdy_busy", req_rdy, 0);
            chk("cs_n", cs_n, (c == v.exp_desel) ? 1 : 0);
            if (c <= 2 + A) begin
                chk("oe_cmdaddr", sio_oe, 2'b11);
                if (c == 1)      n = cmd[7:4];
                else if (c == 2) n = cmd[3:0];
                else             n = v.addr[4*(A-1-(c-3)) +: 4];
                chk("sio_cmdaddr", sio, {n, n});
            end else if (c >= ds && c <= de && v.wr) begin
                chk("oe_wdata", sio_oe, 2'b11);
                if (wq.size() == 0) chk("wq_underflow", 1, 0);
                else chk("sio_wdata", sio, wq.pop_front());
            end else begin
                chk("oe_off", sio_oe, 0);
            end
            chk("wr_rdy", wr_rdy, (v.wr && c >= ds - 1 && c <= de - 1) ? 1 : 0);
            chk("rd_vld", rd_vld, (!v.wr && c >= ds + 1 && c <= de + 1) ? 1 : 0);
            if (rd_vld) begin
                if (rdq.size() == 0) chk("rdq_underflow", 1, 0);
                else chk("rd_data", rd_data, rdq.pop_front());
            end
            if (!v.wr && c >= ds && c <= de) begin
                w = word(v.seed, c - ds);
                sio_in = w;
                rdq.push_back(w);
            end
            if (v.wr && c >= ds - 1 && c <= de - 1) begin
                w = word(v.seed, c - (ds - 1));
                wr_data = w;
                wq.push_back(w);
            end
        end
        chk("rdq_empty", rdq.size(), 0);
        chk("wq_empty", wq.size(), 0);
    endtask

    initial begin
        vt[0] = '{0, 16'h1234, 4'd0,  8'h5A, 10, 0};
        vt[1] = '{1, 16'h00F0, 4'd3,  8'h11, 11, 1};
        vt[2] = '{0, 16'hABCD, 4'd2,  8'h3C, 12, 0};
        vt[3] = '{0, 16'h0F0F, 4'd15, 8'h01, 25, 0};
        vt[4] = '{1, 16'h8001, 4'd0,  8'hC3, 8,  0};
        vt[5] = '{1, 16'hFFFF, 4'd15, 8'h7E, 23, 0};

        #1 rst_n = 1'b0;
        #2;
        chk("rst_cs_n", cs_n, 1);
        chk("rst_oe", sio_oe, 0);
        chk("rst_sio", sio, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_rdy", req_rdy, 1);
        chk("rst_rd_vld", rd_vld, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_wr_rdy", wr_rdy, 0);
        chk("rst_cs_n_rel", cs_n, 1);

        for (int i = 0; i < 6; i++) begin
            do_burst(vt[i]);
            if (vt[i].b2b && i < 5) begin
                // Next request already waiting while in DESEL: must not be taken yet.
                req_vld = 1'b1; req_wr = vt[i+1].wr; req_addr = vt[i+1].addr; req_len = vt[i+1].len;
                chk("b2b_rdy_desel", req_rdy, 0);
            end
        end
        @(negedge clk);
        chk("idle_req_rdy", req_rdy, 1);
        chk("idle_cs_n", cs_n, 1);
        chk("idle_rd_vld", rd_vld, 0);

        // Reset in the middle of a write DATA phase.
        @(negedge clk);
        req_vld = 1'b1; req_wr = 1'b1; req_addr = 16'h1000; req_len = 4'd7;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) req_vld = 1'b0;
            if (wr_rdy) wr_data = 8'($urandom);
        end
        chk("midrst_cs_before", cs_n, 0);
        chk("midrst_oe_before", sio_oe, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("midrst_cs_n", cs_n, 1);
        chk("midrst_oe", sio_oe, 0);
        chk("midrst_wr_rdy", wr_rdy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("postrst_wr_rdy", wr_rdy, 0);
            chk("postrst_cs_n", cs_n, 1);
            chk("postrst_rd_vld", rd_vld, 0);
        end
        chk("postrst_req_rdy", req_rdy, 1);

`ifdef IDLI_SQI_CTRL_ABORT_EN
        // Abort during ADDR: DESEL next cycle, no read data at all.
        @(negedge clk);
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 16'h1234; req_len = 4'd3;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) req_vld = 1'b0;
        end
        chk("abort_in_addr_cs", cs_n, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_desel_cs_n", cs_n, 1);
        chk("abort_desel_oe", sio_oe, 0);
        chk("abort_desel_rdy", req_rdy, 0);
        @(negedge clk);
        chk("abort_idle_rdy", req_rdy, 1);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("abort_no_rd_vld", rd_vld, 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
